// File: rtl/config_tx.sv
// Serial configuration transmitter: latches a config word on a START rising edge,
// holds off LINE_PERIOD clocks, then shifts it out MSB-first with a bit clock.
module config_tx #(
  parameter int CLOCK_PERIOD_PS = 20833,
  parameter int BIT_PERIOD_NS   = 400,
  parameter int C_NO_CFG_BITS   = 24
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [15:0]              LINE_PERIOD,
  input  logic [C_NO_CFG_BITS-1:0] INPUT,
  output logic                     TX_END,
  output logic                     TX_DAT,
  output logic                     TX_CLK,
  output logic                     TX_OE
);

  localparam int BIT_CLKS = (BIT_PERIOD_NS * 1000) / CLOCK_PERIOD_PS;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS + 1);
  localparam int BW       = $clog2(C_NO_CFG_BITS + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CLK_HALF = CW'(HALF);
  localparam logic [BW-1:0] BIT_LAST = BW'(C_NO_CFG_BITS - 1);

  generate
    if (BIT_CLKS < 2) begin : g_bit_clks_check
      $error("config_tx: bit period must span at least two clock cycles");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TX   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     start_q;
  logic                     rise;
  logic [15:0]              wait_cnt;
  logic [15:0]              wait_cnt_nxt;
  logic [CW-1:0]            clk_cnt;
  logic [CW-1:0]            clk_cnt_nxt;
  logic [BW-1:0]            bit_cnt;
  logic [BW-1:0]            bit_cnt_nxt;
  logic [C_NO_CFG_BITS-1:0] shreg;
  logic [C_NO_CFG_BITS-1:0] shreg_nxt;
  logic                     tx_end_nxt;

  assign rise = START & ~start_q;

  // Next-state and datapath; START edges outside IDLE are deliberately dropped.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    clk_cnt_nxt  = clk_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    tx_end_nxt   = TX_END;
    case (state)
      S_IDLE: begin
        if (rise) begin
          shreg_nxt    = INPUT;
          tx_end_nxt   = 1'b0;
          wait_cnt_nxt = LINE_PERIOD;
          clk_cnt_nxt  = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = (LINE_PERIOD == 16'd0) ? S_TX : S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 16'd1) begin
          wait_cnt_nxt = 16'd0;
          state_nxt    = S_TX;
        end else begin
          wait_cnt_nxt = wait_cnt - 16'd1;
        end
      end
      S_TX: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          shreg_nxt   = {shreg[C_NO_CFG_BITS-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      S_DONE: begin
        tx_end_nxt = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from next state so they align with it.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      wait_cnt <= 16'd0;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      TX_END   <= 1'b0;
      TX_DAT   <= 1'b0;
      TX_CLK   <= 1'b0;
      TX_OE    <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= START;
      wait_cnt <= wait_cnt_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      TX_END   <= tx_end_nxt;
      TX_OE    <= (state_nxt == S_TX);
      TX_DAT   <= (state_nxt == S_TX) ? shreg_nxt[C_NO_CFG_BITS-1] : 1'b0;
      TX_CLK   <= (state_nxt == S_TX) && (clk_cnt_nxt >= CLK_HALF);
    end
  end

endmodule

// File: tb/tb_config_tx.sv
// Bench for config_tx: table-driven and random frames checked cycle by cycle against
// a waveform model derived from frame timing arithmetic, plus reset corner cases.
module tb_config_tx;

  localparam int NB   = 24;
  localparam int BCLK = 19;   // 400 ns / 20.833 ns, truncated
  localparam int HLF  = 9;
  localparam int TXC  = NB * BCLK;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   line_period = 16'd0;
  logic [NB-1:0] cfg_in = '0;
  logic          tx_end, tx_dat, tx_clk, tx_oe;

  int n_tests = 0;
  int n_fail  = 0;

  config_tx dut (
    .CLOCK(clock), .RESET(reset), .START(start), .LINE_PERIOD(line_period),
    .INPUT(cfg_in), .TX_END(tx_end), .TX_DAT(tx_dat), .TX_CLK(tx_clk), .TX_OE(tx_oe)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0]   lp;
    logic [NB-1:0] word;
    int            hold;
    int            rerise;
    int            exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected {TX_END, TX_OE, TX_CLK, TX_DAT} t cycles after the edge that sees the START rise.
  function automatic logic [3:0] model_out(input int t, input int lp, input logic [NB-1:0] w);
    int j;
    if (t < lp) return 4'b0000;
    if (t < lp + TXC) begin
      j = t - lp;
      return {1'b0, 1'b1, ((j % BCLK) >= HLF), w[NB-1-(j / BCLK)]};
    end
    if (t == lp + TXC) return 4'b0000;
    return 4'b1000;
  endfunction

  task automatic run_frame(input logic [15:0] lp, input logic [NB-1:0] w, input int hold,
                           input int rerise, input int exp_len, input string tag);
    int errs, first_bad, rises, oe_cycles, t_end, t_oe;
    logic [NB-1:0] cap;
    logic prev_clk;
    logic [3:0] act_o, exp_o;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    line_period = lp; cfg_in = w; start = 1'b1;
    errs = 0; first_bad = -1; rises = 0; oe_cycles = 0; t_end = -1; t_oe = -1;
    cap = '0; prev_clk = 1'b0;
    for (int t = 0; t < int'(lp) + TXC + 100 && t_end < 0; t++) begin
      @(posedge clock); #1;
      act_o = {tx_end, tx_oe, tx_clk, tx_dat};
      exp_o = model_out(t, int'(lp), w);
      if (act_o !== exp_o) begin
        errs++;
        if (first_bad < 0) first_bad = t;
      end
      if (tx_oe) begin
        oe_cycles++;
        if (t_oe < 0) t_oe = t;
      end
      if (tx_clk && !prev_clk) begin
        rises++;
        cap = {cap[NB-2:0], tx_dat};
      end
      prev_clk = tx_clk;
      if (tx_end) t_end = t;
      if (t == hold) start = 1'b0;
      if (t == rerise) begin
        start = 1'b1;
        cfg_in = ~w;
      end else if (t % 37 == 5) begin
        cfg_in = $urandom;
      end
    end
    check($sformatf("%s wave (first bad cycle %0d)", tag, first_bad), errs, 0);
    check({tag, " end_seen"}, (t_end >= 0), 1);
    check_range({tag, " frame_len"}, t_end + 1, exp_len - 1, exp_len + 1);
    check({tag, " clk_rises"}, rises, NB);
    check({tag, " word"}, cap, w);
    check({tag, " oe_cycles"}, oe_cycles, TXC);
    check_range({tag, " first_oe"}, t_oe, int'(lp), int'(lp) + 1);
    check({tag, " end_after_oe"}, (t_end >= t_oe + oe_cycles), 1);
    // No second frame may follow, whatever START does afterwards.
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (tx_oe !== 1'b0 || tx_end !== 1'b1) errs++;
    end
    check({tag, " idle_after"}, errs, 0);
  endtask

  initial begin
    int errs;
    logic [15:0] rlp;
    logic [NB-1:0] rw;

    vecs[0] = '{16'd4000, 24'hAEC9EC, 0,    -1,  4458};
    vecs[1] = '{16'd4000, 24'h123456, 480,  528, 4458};
    vecs[2] = '{16'd0,    24'h5A5A5A, 3,    -1,  458};
    vecs[3] = '{16'd1,    24'hFFFFFF, 2000, -1,  459};
    vecs[4] = '{16'd2,    24'h000001, 1,    200, 460};
    vecs[5] = '{16'd17,   24'h800000, 0,    -1,  475};

    // Reset held low while START toggles: nothing may move.
    #1;
    check("reset_state", {tx_end, tx_oe, tx_clk, tx_dat}, 4'b0000);
    errs = 0;
    line_period = 16'd0;
    cfg_in = 24'hFFFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); start = ~start;
      @(posedge clock); #1;
      if ({tx_end, tx_oe, tx_clk, tx_dat} !== 4'b0000) errs++;
    end
    check("reset_hold_quiet", errs, 0);
    @(negedge clock); start = 1'b0;
    @(negedge clock); reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("post_reset_idle", {tx_end, tx_oe, tx_clk, tx_dat}, 4'b0000);

    for (int k = 0; k < 6; k++)
      run_frame(vecs[k].lp, vecs[k].word, vecs[k].hold, vecs[k].rerise, vecs[k].exp_len,
                $sformatf("vec%0d", k));

    for (int k = 0; k < 8; k++) begin
      rlp = 16'($urandom_range(0, 40));
      rw  = NB'($urandom);
      run_frame(rlp, rw, int'($urandom_range(0, 100)), -1, int'(rlp) + TXC + 2,
                $sformatf("rand%0d", k));
    end

    // Mid-frame reset during bit 10 aborts asynchronously.
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    line_period = 16'd3; cfg_in = 24'hFFFFFF; start = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    check("midreset_active", tx_oe, 1'b1);
    #2; reset = 1'b0;
    #1;
    check("midreset_async", {tx_end, tx_oe, tx_clk, tx_dat}, 4'b0000);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if ({tx_end, tx_oe, tx_clk, tx_dat} !== 4'b0000) errs++;
    end
    check("midreset_stays_idle", errs, 0);
    run_frame(16'd5, 24'hC3A50F, 2, -1, 5 + TXC + 2, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
